// File: rtl/aon_uart_pkg.sv
// Shared types and frame constants for the always-on UART transmitter.
package aon_uart_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    typedef logic [DATA_BITS-1:0] byte_t;

endpackage

// File: rtl/aon_uart_tx_if.sv
// Byte handshake between a data source and the UART transmitter.
interface aon_uart_tx_if;
    import aon_uart_pkg::*;

    byte_t DIN;
    logic  VALID;
    logic  READY;

    modport master (output DIN, output VALID, input READY);
    modport slave  (input DIN, input VALID, output READY);

endinterface

// File: rtl/aon_baud_tick.sv
// Bit-period counter; tick marks the last clock of every serial bit.
module aon_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic C,
    input  logic RN,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Wraps on the bit-end tick so the count never passes CLKS_PER_BIT-1.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aon_uart_tx.sv
// 8N1 LSB-first serial transmitter with a valid/ready byte input.
module aon_uart_tx
    import aon_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic               C,
    input  logic               RN,
    aon_uart_tx_if.slave       bus,
    output logic               TXD,
    output logic               BUSY
);

    state_e     state_q, state_d;
    byte_t      shreg_q, shreg_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       txd_q, txd_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       tick;

    aon_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .C    (C),
        .RN   (RN),
        .clr  (state_q == ST_IDLE),
        .tick (tick)
    );

    assign TXD       = txd_q;
    assign BUSY      = busy_q;
    assign bus.READY = ready_q;

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic computes the line level for the coming cycle so TXD stays a flop output.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.VALID && ready_q) begin
                    state_d   = ST_START;
                    shreg_d   = bus.DIN;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    txd_d     = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d   = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aon_uart_tx.sv
// Directed bench for aon_uart_tx at CLKS_PER_BIT=4 and the CLKS_PER_BIT=2 corner.
module tb_aon_uart_tx;
    import aon_uart_pkg::*;

    logic C;
    logic RN;
    logic txd_a, busy_a, txd_b, busy_b;
    int   n_vec;
    int   n_err;

    aon_uart_tx_if bus_a ();
    aon_uart_tx_if bus_b ();

    aon_uart_tx #(.CLKS_PER_BIT(4)) dut_a (
        .C    (C),
        .RN   (RN),
        .bus  (bus_a),
        .TXD  (txd_a),
        .BUSY (busy_a)
    );

    aon_uart_tx #(.CLKS_PER_BIT(2)) dut_b (
        .C    (C),
        .RN   (RN),
        .bus  (bus_b),
        .TXD  (txd_b),
        .BUSY (busy_b)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame slot idx: start, 8 data bits LSB first, stop.
    function automatic logic fbit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Entered at the falling edge right after the accept edge; leaves one cycle after the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] b, input int cpb,
                               input bit use_b, input bit pulse);
        for (int i = 0; i < FRAME_BITS * cpb; i++) begin
            if (pulse && i == 12) begin
                bus_a.VALID = 1'b1;
                bus_a.DIN   = 8'h0F;
            end
            if (pulse && i == 14) bus_a.VALID = 1'b0;
            chk($sformatf("%s txd c%0d", tag, i), use_b ? txd_b : txd_a, fbit(b, i / cpb));
            chk($sformatf("%s ready c%0d", tag, i), use_b ? bus_b.READY : bus_a.READY, 0);
            chk($sformatf("%s busy c%0d", tag, i), use_b ? busy_b : busy_a, 1);
            if (use_b)
                chk($sformatf("%s cnt<=1 c%0d", tag, i), 32'(dut_b.u_baud.cnt_q <= 1'b1), 1);
            @(negedge C);
        end
        chk({tag, " ready end"}, use_b ? bus_b.READY : bus_a.READY, 1);
        chk({tag, " busy end"}, use_b ? busy_b : busy_a, 0);
        chk({tag, " txd end"}, use_b ? txd_b : txd_a, 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RN          = 1'b0;
        bus_a.VALID = 1'b1;
        bus_a.DIN   = 8'h77;
        bus_b.VALID = 1'b1;
        bus_b.DIN   = 8'h77;

        // Reset held with VALID high: no accept
        repeat (3) @(negedge C);
        chk("rst txd_a", txd_a, 1);
        chk("rst ready_a", bus_a.READY, 1);
        chk("rst busy_a", busy_a, 0);
        chk("rst txd_b", txd_b, 1);
        chk("rst ready_b", bus_b.READY, 1);
        chk("rst busy_b", busy_b, 0);
        chk("rst state_a", 32'(dut_a.state_q), 32'(ST_IDLE));

        // Single frame 0xA5, accepted on the first edge after release
        RN          = 1'b1;
        bus_b.VALID = 1'b0;
        bus_a.DIN   = 8'hA5;
        @(negedge C);
        bus_a.VALID = 1'b0;
        bus_a.DIN   = 8'h00;
        check_frame("a5", 8'hA5, 4, 1'b0, 1'b0);

        // Back-to-back 0x00 then 0xFF with VALID held throughout
        bus_a.VALID = 1'b1;
        bus_a.DIN   = 8'h00;
        @(negedge C);
        bus_a.DIN   = 8'hFF;
        check_frame("b2b0", 8'h00, 4, 1'b0, 1'b0);
        @(negedge C);
        bus_a.VALID = 1'b0;
        check_frame("b2b1", 8'hFF, 4, 1'b0, 1'b0);

        // DIN change and VALID pulse during a frame are ignored
        @(negedge C);
        bus_a.VALID = 1'b1;
        bus_a.DIN   = 8'hC3;
        @(negedge C);
        bus_a.VALID = 1'b0;
        bus_a.DIN   = 8'h81;
        check_frame("pulse", 8'hC3, 4, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge C);
            chk("pulse no refire txd", txd_a, 1);
            chk("pulse no refire busy", busy_a, 0);
        end

        // Asynchronous reset during data bit 3 of 0x5A
        bus_a.VALID = 1'b1;
        bus_a.DIN   = 8'h5A;
        @(negedge C);
        bus_a.VALID = 1'b0;
        bus_a.DIN   = 8'h00;
        repeat (17) @(negedge C);
        chk("mid bit3 txd", txd_a, 1);
        chk("mid busy", busy_a, 1);
        chk("mid state", 32'(dut_a.state_q), 32'(ST_DATA));
        #2 RN = 1'b0;
        #1;
        chk("async txd", txd_a, 1);
        chk("async ready", bus_a.READY, 1);
        chk("async busy", busy_a, 0);
        chk("async state", 32'(dut_a.state_q), 32'(ST_IDLE));
        @(negedge C);
        RN = 1'b1;
        repeat (2) begin
            @(negedge C);
            chk("post rst idle txd", txd_a, 1);
            chk("post rst idle busy", busy_a, 0);
        end
        bus_a.VALID = 1'b1;
        bus_a.DIN   = 8'h3C;
        @(negedge C);
        bus_a.VALID = 1'b0;
        check_frame("3c", 8'h3C, 4, 1'b0, 1'b0);

        // CLKS_PER_BIT=2 corner: 20-cycle frame
        bus_b.VALID = 1'b1;
        bus_b.DIN   = 8'h96;
        @(negedge C);
        bus_b.VALID = 1'b0;
        bus_b.DIN   = 8'h00;
        check_frame("cpb2", 8'h96, 2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
